// File: rtl/instr_mem_loader_if.sv
// Fetch and byte-loader signal bundle for instr_mem_loader.
// Fetch side: request in, registered word out. Loader side: byte valid/ready, start/end pulses.
// master drives requests and bytes, slave (the memory) drives data, ready and status.
interface instr_mem_loader_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              fetch_en;
    logic [ADDR_W-1:0] fetch_addr;
    logic [DATA_W-1:0] instr_out;
    logic              instr_valid;
    logic              load_start;
    logic              load_valid;
    logic [7:0]        load_byte;
    logic              load_ready;
    logic              load_end;
    logic              load_done;
    logic [ADDR_W-1:0] load_count;
    logic              err_ovf;
    logic              err_fetch;

    modport master (
        output fetch_en, fetch_addr, load_start, load_valid, load_byte, load_end,
        input  instr_out, instr_valid, load_ready, load_done, load_count, err_ovf, err_fetch
    );

    modport slave (
        input  fetch_en, fetch_addr, load_start, load_valid, load_byte, load_end,
        output instr_out, instr_valid, load_ready, load_done, load_count, err_ovf, err_fetch
    );
endinterface

// File: rtl/instr_mem_loader.sv
// Parametrised instruction memory with a little-endian byte-stream program loader.
// Latency: fetch returns 1 cycle after request; loader writes a word on the edge of its last byte.
// Backpressure: load_ready high only in LOAD; fetches outside RUN are dropped, never queued.
module instr_mem_loader #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16,
    parameter int DEPTH     = 256,
    parameter int FILL_WORD = 51
) (
    input  logic clk,
    input  logic rst,
    instr_mem_loader_if.slave bus
);
    localparam int                BYTES     = DATA_W / 8;
    localparam int                IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                PTR_W     = ADDR_W + 1;
    localparam logic [PTR_W-1:0]  DEPTH_P   = PTR_W'(DEPTH);
    localparam logic [2:0]        LAST_BYTE = 3'(BYTES - 1);
    localparam logic [DATA_W-1:0] FILL_P    = DATA_W'(FILL_WORD);

    typedef enum logic [1:0] {RUN, LOAD, PAD} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] instr_out_q, instr_out_d;
    logic              instr_valid_q, instr_valid_d;
    logic              load_done_q, load_done_d;
    logic              err_ovf_q, err_ovf_d;
    logic              err_fetch_q, err_fetch_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [2:0]        byte_cnt_q, byte_cnt_d;
    logic [DATA_W-1:0] wbuf_q, wbuf_d;
    logic [DATA_W-1:0] asm_word;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic              accept, full, in_range, load_ready;

    logic [DATA_W-1:0] mem [DEPTH];

    assign accept   = (state_q == LOAD) && bus.load_valid;
    assign full     = (wr_ptr_q == DEPTH_P);
    assign in_range = ({1'b0, bus.fetch_addr} < DEPTH_P);

    // State register; reset in the middle of a load simply abandons it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= RUN;
        else     state_q <= state_d;
    end

    // Next state: load_start wins over load_end in RUN; a partial word detours through PAD.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:  if (bus.load_start) state_d = LOAD;
            LOAD: if (bus.load_end)   state_d = (byte_cnt_d == 3'd0) ? RUN : PAD;
            PAD:  state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // FSM outputs: the loader only accepts bytes while in LOAD.
    always_comb begin
        load_ready = (state_q == LOAD);
    end

    // Current byte dropped into the word under assembly at lane byte_cnt (little-endian).
    always_comb begin
        asm_word = wbuf_q;
        asm_word[{byte_cnt_q, 3'b000} +: 8] = bus.load_byte;
    end

    // Datapath next values: fetch, word assembly, write pointer and sticky errors.
    always_comb begin
        instr_out_d   = instr_out_q;
        instr_valid_d = 1'b0;
        err_fetch_d   = err_fetch_q;
        err_ovf_d     = err_ovf_q;
        wr_ptr_d      = wr_ptr_q;
        byte_cnt_d    = byte_cnt_q;
        wbuf_d        = wbuf_q;
        mem_we        = 1'b0;
        mem_wdata     = wbuf_q;
        load_done_d   = (state_q != RUN) && (state_d == RUN);

        if (state_q == RUN && bus.fetch_en) begin
            instr_valid_d = 1'b1;
            if (in_range) begin
                instr_out_d = mem[bus.fetch_addr[IDX_W-1:0]];
            end else begin
                instr_out_d = FILL_P;
                err_fetch_d = 1'b1;
            end
        end

        if (state_q == RUN && bus.load_start) begin
            wr_ptr_d   = '0;
            byte_cnt_d = '0;
            wbuf_d     = '0;
            err_ovf_d  = 1'b0;
        end

        if (accept) begin
            if (full) begin
                // Memory already full: swallow the byte, flag it, keep the counter still.
                err_ovf_d = 1'b1;
            end else if (byte_cnt_q == LAST_BYTE) begin
                mem_we     = 1'b1;
                mem_wdata  = asm_word;
                wr_ptr_d   = wr_ptr_q + PTR_W'(1);
                byte_cnt_d = '0;
                wbuf_d     = '0;
            end else begin
                wbuf_d     = asm_word;
                byte_cnt_d = byte_cnt_q + 3'd1;
            end
        end

        if (state_q == PAD) begin
            // Upper lanes of wbuf are still zero, which gives the zero padding for free.
            if (!full) begin
                mem_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            byte_cnt_d = '0;
            wbuf_d     = '0;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_out_q   <= '0;
            instr_valid_q <= 1'b0;
            load_done_q   <= 1'b0;
            err_ovf_q     <= 1'b0;
            err_fetch_q   <= 1'b0;
            wr_ptr_q      <= '0;
            byte_cnt_q    <= '0;
            wbuf_q        <= '0;
        end else begin
            instr_out_q   <= instr_out_d;
            instr_valid_q <= instr_valid_d;
            load_done_q   <= load_done_d;
            err_ovf_q     <= err_ovf_d;
            err_fetch_q   <= err_fetch_d;
            wr_ptr_q      <= wr_ptr_d;
            byte_cnt_q    <= byte_cnt_d;
            wbuf_q        <= wbuf_d;
        end
    end

    // Memory write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_ptr_q[IDX_W-1:0]] <= mem_wdata;
    end

    assign bus.instr_out   = instr_out_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.load_ready  = load_ready;
    assign bus.load_done   = load_done_q;
    assign bus.load_count  = wr_ptr_q[ADDR_W-1:0];
    assign bus.err_ovf     = err_ovf_q;
    assign bus.err_fetch   = err_fetch_q;
endmodule
